// File: rtl/midi_msg_tx_pkg.sv
// Shared definitions for the MIDI message framer and the future receive parser:
// FSM state encoding, MIDI status range constants and a channel-voice helper.
package midi_msg_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } tx_state_e;

    localparam logic [7:0] NOTE_OFF = 8'h80;  // first channel-voice status
    localparam logic [7:0] SYS_BASE = 8'hF0;  // first system-common status
    localparam logic [7:0] RT_BASE  = 8'hF8;  // first real-time status

    // Channel-voice messages occupy 0x80..0xEF.
    function automatic logic is_channel_voice(input logic [7:0] status);
        return (status >= NOTE_OFF) && (status < SYS_BASE);
    endfunction

endpackage

// File: rtl/midi_msg_tx_len_decode.sv
// midi_len_decode: maps a MIDI status byte to its total message length
// (status byte included) and flags statuses that cannot start a message.
module midi_len_decode
    import midi_msg_tx_pkg::*;
(
    input  logic [7:0] status_i,
    output logic [1:0] len_o,
    output logic       valid_o
);

    // Length table; undefined system statuses and data bytes are invalid.
    always_comb begin
        len_o   = 2'd0;
        valid_o = 1'b0;
        if (is_channel_voice(status_i)) begin
            valid_o = 1'b1;
            // Program change and channel pressure (0xC0..0xDF) carry one data byte.
            len_o   = (status_i[7:5] == 3'b110) ? 2'd2 : 2'd3;
        end else if (status_i >= RT_BASE) begin
            valid_o = 1'b1;
            len_o   = 2'd1;
        end else if (status_i >= SYS_BASE) begin
            case (status_i)
                8'hF1, 8'hF3: begin valid_o = 1'b1; len_o = 2'd2; end
                8'hF2:        begin valid_o = 1'b1; len_o = 2'd3; end
                8'hF6:        begin valid_o = 1'b1; len_o = 2'd1; end
                default:      begin valid_o = 1'b0; len_o = 2'd0; end
            endcase
        end
    end

endmodule

// File: rtl/midi_msg_tx.sv
// midi_msg_tx: frames one MIDI message per handshake into the byte stream of
// an 8N1 UART transmitter (one-cycle send pulse, busy flag back).
// Optional build macro MIDI_RUNNING_STATUS_EN suppresses a repeated
// channel-voice status byte.
//
// Handshake: a message is taken on any rising clk edge where
// msg_valid & msg_ready; msg_ready is high exactly while the FSM is idle,
// and the msg_* inputs are latched at that edge and may change afterwards.
module midi_msg_tx
    import midi_msg_tx_pkg::*;
#(
    parameter int STALL_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [6:0] msg_data1,
    input  logic [6:0] msg_data2,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_busy,
    output logic       msg_err
);

    localparam int SW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT);

    tx_state_e   state_q;
    logic [7:0]  status_q;
    logic [6:0]  data1_q;
    logic [6:0]  data2_q;
    logic [1:0]  len_q;
    logic [1:0]  idx_q;
    logic [SW-1:0] stall_q;
    logic [7:0]  tx_data_q;
    logic        tx_send_q;
    logic        msg_err_q;

    logic [1:0]  dec_len;
    logic        dec_valid;
    logic [7:0]  cur_byte;
    logic [2:0]  idx_inc_d;
    logic [1:0]  start_idx_d;

    midi_len_decode u_len_decode (
        .status_i (msg_status),
        .len_o    (dec_len),
        .valid_o  (dec_valid)
    );

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status_q;

    // A repeated channel-voice status is implied by the receiver; start at data1.
    always_comb begin
        start_idx_d = 2'd0;
        if (is_channel_voice(msg_status) && (msg_status == last_status_q)) begin
            start_idx_d = 2'd1;
        end
    end

    // Running-status memory: set by channel voice, cleared by system common and aborts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_status_q <= 8'h00;
        end else if ((state_q == ST_IDLE) && msg_valid) begin
            if (is_channel_voice(msg_status)) begin
                last_status_q <= msg_status;
            end else if ((msg_status >= SYS_BASE) && (msg_status < RT_BASE)) begin
                last_status_q <= 8'h00;
            end
        end else if ((state_q == ST_WAIT_START) && !tx_busy &&
                     (stall_q == SW'(STALL_LIMIT - 1))) begin
            last_status_q <= 8'h00;
        end
    end
`else
    // Without running status every message starts with its status byte.
    always_comb begin
        start_idx_d = 2'd0;
    end
`endif

    // Byte selection for the current index and the index increment.
    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = status_q;
            2'd1:    cur_byte = {1'b0, data1_q};
            default: cur_byte = {1'b0, data2_q};
        endcase
        idx_inc_d = {1'b0, idx_q} + 3'd1;
    end

    // Framing FSM with registered transmitter-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            status_q  <= 8'h00;
            data1_q   <= 7'h00;
            data2_q   <= 7'h00;
            len_q     <= 2'd0;
            idx_q     <= 2'd0;
            stall_q   <= '0;
            tx_data_q <= 8'h00;
            tx_send_q <= 1'b0;
            msg_err_q <= 1'b0;
        end else begin
            msg_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (msg_valid) begin
                        status_q <= msg_status;
                        data1_q  <= msg_data1;
                        data2_q  <= msg_data2;
                        if (dec_valid) begin
                            len_q   <= dec_len;
                            idx_q   <= start_idx_d;
                            state_q <= ST_LOAD;
                        end else begin
                            msg_err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // Only hand over a byte once the transmitter is free.
                    if (!tx_busy) begin
                        tx_data_q <= cur_byte;
                        tx_send_q <= 1'b1;
                        stall_q   <= '0;
                        state_q   <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    tx_send_q <= 1'b0;
                    if (tx_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (stall_q == SW'(STALL_LIMIT - 1)) begin
                        // Transmitter never acknowledged: drop the rest of the frame.
                        msg_err_q <= 1'b1;
                        idx_q     <= 2'd0;
                        state_q   <= ST_IDLE;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (idx_inc_d < {1'b0, len_q}) begin
                            idx_q   <= idx_inc_d[1:0];
                            state_q <= ST_LOAD;
                        end else begin
                            idx_q   <= 2'd0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign msg_ready = (state_q == ST_IDLE);
    assign tx_data   = tx_data_q;
    assign tx_send   = tx_send_q;
    assign msg_err   = msg_err_q;

endmodule

// File: tb/tb_midi_msg_tx.sv
// Testbench for midi_msg_tx: directed MIDI messages followed by randomized
// ones, with a UART transmitter model and a scoreboard of expected bytes
// built from the MIDI length table.
module tb_midi_msg_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic       msg_err;

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0] exp_q[$];
    int  exp_err       = 0;
    int  err_seen      = 0;
    int  n_sends       = 0;
    int  cyc           = 0;
    int  last_send_cyc = 0;
    int  last_err_cyc  = 0;
    int  acc_cyc       = 0;
    logic [7:0] model_last = 8'h00;
    bit  uart_dead = 1'b0;
    bit  rand_hold = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    midi_msg_tx #(.STALL_LIMIT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_busy    (tx_busy),
        .msg_err    (msg_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Total bytes of a message by status; 0 means the status is rejected.
    function automatic int spec_len(input logic [7:0] s);
        if (s < 8'h80) return 0;
        if (s < 8'hC0) return 3;
        if (s < 8'hE0) return 2;
        if (s < 8'hF0) return 3;
        if (s >= 8'hF8) return 1;
        if (s == 8'hF1 || s == 8'hF3) return 2;
        if (s == 8'hF2) return 3;
        if (s == 8'hF6) return 1;
        return 0;
    endfunction

    // ---------------- UART transmitter model ----------------
    initial begin
        int h;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send && !uart_dead && !reset) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                h = rand_hold ? $urandom_range(1, 20) : 20;
                repeat (h) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (tx_send) begin
                    n_sends++;
                    last_send_cyc = cyc;
                    check_eq("tx_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check_eq("tx_data", tx_data, exp_q.pop_front());
                end
                if (msg_err) begin
                    err_seen++;
                    last_err_cyc = cyc;
                end
                if (tx_send || msg_err) check_eq("err_send_excl", tx_send && msg_err, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic accept_msg(input logic [7:0] s, input logic [6:0] d1, input logic [6:0] d2);
        int t;
        int n;
        int first;
        logic [7:0] bytes[3];
        logic ready_exp;
        t = 0;
        @(negedge clk);
        while (!msg_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_before_accept", msg_ready, 1);
        msg_status = s;
        msg_data1  = d1;
        msg_data2  = d2;
        msg_valid  = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        msg_valid  = 1'b0;
        msg_status = 8'($urandom);
        msg_data1  = 7'($urandom);
        msg_data2  = 7'($urandom);
        n = spec_len(s);
        if (n == 0) begin
            exp_err++;
            ready_exp = 1'b1;
        end else begin
            bytes[0] = s;
            bytes[1] = {1'b0, d1};
            bytes[2] = {1'b0, d2};
            first = 0;
`ifdef MIDI_RUNNING_STATUS_EN
            if (s >= 8'h80 && s < 8'hF0 && s == model_last) first = 1;
`endif
            for (int i = first; i < n; i++) exp_q.push_back(bytes[i]);
            ready_exp = 1'b0;
        end
`ifdef MIDI_RUNNING_STATUS_EN
        if (s >= 8'h80 && s < 8'hF0) model_last = s;
        else if (s >= 8'hF0 && s < 8'hF8) model_last = 8'h00;
`endif
        @(negedge clk);
        check_eq("ready_after_accept", msg_ready, ready_exp);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(msg_ready && !tx_busy && exp_q.size() == 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("msg_done_in_time", t < 3000, 1);
        check_eq("err_count", err_seen, exp_err);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int lat;
        int sends_before;
        logic [7:0] first_byte;
        logic [7:0] pick[6];
        pick[0] = 8'h90; pick[1] = 8'h91; pick[2] = 8'hC5;
        pick[3] = 8'hF8; pick[4] = 8'hE0; pick[5] = 8'hF2;

        reset      = 1'b1;
        msg_valid  = 1'b0;
        msg_status = 8'h00;
        msg_data1  = 7'h00;
        msg_data2  = 7'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", msg_ready, 1);
        check_eq("rst_send", tx_send, 0);
        check_eq("rst_data", tx_data, 8'h00);
        check_eq("rst_err", msg_err, 0);
        reset = 1'b0;

        // Note on; also measure latency: the pulse seen after edge acc+1 is
        // what the transmitter samples on edge acc+2.
        accept_msg(8'h90, 7'h3C, 7'h64);
        t = 0;
        while (!tx_send && t < 10) begin
            @(negedge clk);
            t++;
        end
        lat = cyc - acc_cyc + 1;
        check_eq("first_send_latency", lat, 2);
        wait_idle();

        // Real-time in between, then a note on with the same status.
        accept_msg(8'hF8, 7'h00, 7'h00);
        wait_idle();
        accept_msg(8'h90, 7'h3E, 7'h64);
        wait_idle();

        accept_msg(8'hC5, 7'h07, 7'h55);
        wait_idle();
        accept_msg(8'hF8, 7'h11, 7'h22);
        wait_idle();

        // Data byte as status: rejected.
        sends_before = n_sends;
        accept_msg(8'h3C, 7'h01, 7'h02);
        wait_idle();
        check_eq("reject_no_send", n_sends, sends_before);

        // Tune request clears running status before the reset test.
        accept_msg(8'hF6, 7'h00, 7'h00);
        wait_idle();

        // Reset between the status byte and the first data byte.
        accept_msg(8'h90, 7'h3C, 7'h64);
        t = 0;
        while (!tx_busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("busy_before_reset", tx_busy, 1);
        sends_before = n_sends;
        reset = 1'b1;
        #1;
        check_eq("midrst_send", tx_send, 0);
        check_eq("midrst_ready", msg_ready, 1);
        check_eq("midrst_data", tx_data, 8'h00);
        exp_q.delete();
        model_last = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("no_send_after_reset", n_sends, sends_before);
        check_eq("ready_after_reset", msg_ready, 1);

        // Stalled transmitter: only the first byte goes out, then abort.
        uart_dead = 1'b1;
        accept_msg(8'h90, 7'h3C, 7'h64);
        first_byte = exp_q[0];
        exp_q.delete();
        exp_q.push_back(first_byte);
        model_last = 8'h00;
        exp_err++;
        t = 0;
        while (err_seen < exp_err && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("stall_err_seen", err_seen, exp_err);
        check_eq("stall_gap", last_err_cyc - last_send_cyc, 16);
        sends_before = n_sends;
        repeat (30) @(negedge clk);
        check_eq("stall_no_more_sends", n_sends, sends_before);
        check_eq("stall_ready", msg_ready, 1);
        uart_dead = 1'b0;
        wait_idle();

        // Randomized messages and transmitter busy times.
        rand_hold = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] s;
            if ($urandom_range(0, 1) == 1) s = pick[$urandom_range(0, 5)];
            else s = 8'($urandom_range(0, 255));
            accept_msg(s, 7'($urandom), 7'($urandom));
            wait_idle();
        end

        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        n_errs++;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/midi_msg_tx.md
Name: midi_msg_tx

Overview:
- MIDI message framer sitting directly upstream of the 8N1 UART transmitter in the MIDI-out path.
- Accepts one complete MIDI message per valid/ready handshake and derives the byte count from the status byte.
- Emits the bytes in order (status, data1, data2) to the transmitter using its one-cycle send pulse and its busy flag.
- Reports malformed messages and a stalled transmitter on a one-cycle error pulse.

Parameters:
- STALL_LIMIT, 16: max clk cycles from tx_send to tx_busy rising before the message is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active high
- msg_valid  in  1  message present on msg_* inputs
- msg_ready  out  1  block can accept a message this cycle
- msg_status  in  8  MIDI status byte; bit7 must be 1
- msg_data1  in  7  first data byte
- msg_data2  in  7  second data byte
- tx_data  out  8  byte presented to the UART transmitter
- tx_send  out  1  one-cycle send pulse to the transmitter
- tx_busy  in  1  transmitter busy flag
- msg_err  out  1  one-cycle pulse: bad status or stall abort

Behaviour:
- Reset (async, active high): state IDLE, msg_ready=1, tx_send=0, tx_data=8'h00, msg_err=0, byte counter=0, stall counter=0.
- msg_ready = (state==IDLE), combinational from state.
- Accept occurs when msg_valid & msg_ready. On accept, latch all msg_* inputs and compute length N:
  - status 0x80-0xBF or 0xE0-0xEF: N=3
  - status 0xC0-0xDF, 0xF1 or 0xF3: N=2
  - status 0xF6 or 0xF8-0xFF: N=1
  - status 0xF2: N=3
  - status bit7=0, or 0xF0/0xF4/0xF5/0xF7: rejected. msg_err pulses the cycle after accept, state stays IDLE, nothing is sent.
- Data bytes go out as {1'b0, data}.
- FSM states:
  - IDLE: waits for accept.
  - LOAD: drive tx_data with byte[idx] and assert tx_send for exactly one cycle, only when tx_busy=0; otherwise hold. Go to WAIT_START.
  - WAIT_START: wait for tx_busy=1, then go to WAIT_DONE. If STALL_LIMIT cycles pass without busy, pulse msg_err and return to IDLE (abort).
  - WAIT_DONE: on tx_busy=0, idx++. Go to LOAD if idx<N, else IDLE.
- tx_data holds its value from LOAD until the next LOAD.
- Latency: first tx_send occurs 2 cycles after the accept edge when tx_busy=0.
- msg_valid is ignored outside IDLE. Inputs may change freely after accept.
- Reset asserted mid-message: the frame is abandoned immediately and no further tx_send is issued. The transmitter's own reset governs its line.
- msg_err and tx_send are never high in the same cycle.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- When defined:
  - Keep a last_status register (reset 0x00).
  - A channel-voice status (0x80-0xEF) equal to last_status skips the status byte; N is reduced by 1.
  - Any sent channel-voice status updates last_status.
  - 0xF0-0xF7 clears last_status to 0x00.
  - 0xF8-0xFF (real-time) leaves last_status unchanged.
  - An aborted message clears last_status.
- When undefined: the status byte is always sent and no last_status register exists.

Decomposition:
- Shared package holds the FSM state encoding (IDLE, LOAD, WAIT_START, WAIT_DONE) and MIDI status range constants (NOTE_OFF=0x80, SYS_BASE=0xF0, RT_BASE=0xF8).
- One sub-module, midi_len_decode: combinational status in, 2-bit length plus valid flag out. Reused by the future receive parser.

Test Plan:
- Status 0x90, data1 0x3C, data2 0x64, with a bench UART model (busy 1 cycle after send, held 20 cycles) -> tx_data sequence 0x90,0x3C,0x64. Three tx_send pulses, msg_ready back high after the final busy fall.
- Status 0xC5, data1 0x07 -> exactly two sends, 0xC5,0x07. Status 0xF8 -> single send 0xF8.
- Status 0x3C -> no tx_send, msg_err pulses once, msg_ready stays 1.
- tx_busy tied 0 after the first send -> msg_err pulses 16 cycles after tx_send, state IDLE, no further sends.
- Reset asserted between byte 1 and byte 2 of 0x90/0x3C/0x64 -> tx_send=0 immediately, msg_ready=1 after release, no 0x3C emitted.
- With MIDI_RUNNING_STATUS_EN: send 0x90/0x3C/0x64, then 0x90/0x3E/0x64 -> second message emits only 0x3E,0x64. Inserting 0xF8 between them does not break running status.
